load_writeback_unit: RTL and testbench
======================================

// Module: load_writeback_unit
// PURPOSE
//   Multi-cycle load unit directly upstream of the register bank write port.
//   Accepts a load (base from register-bank read port 1, signed offset, dest), issues one
//   memory read, waits for ack, extracts/extends the addressed lane, then pulses the
//   writeback (dest + data) that drives the bank's Dest/ldr_in inputs. One load in flight.
// PARAMETERS
//   ADDR_W   32  address width
//   DATA_W   32  data / register width (fixed 32 for lane logic)
//   TIMEOUT  16  cycles waiting for mem_ack before abort (LDR_TIMEOUT_EN only)
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous, active-high reset
//   ld_valid   in   1       load request valid
//   ld_ready   out  1       unit can accept a request (1 only in IDLE)
//   ld_dest    in   4       destination register index
//   ld_base    in   32      base address (register-bank read data)
//   ld_offset  in   12      signed byte offset
//   ld_size    in   2       00 word, 01 half, 10 byte, 11 treated as word
//   ld_signed  in   1       1 = sign-extend half/byte, 0 = zero-extend
//   mem_req    out  1       memory read request, held until ack
//   mem_addr   out  32      word-aligned read address
//   mem_ack    in   1       read data valid this cycle
//   mem_rdata  in   32      read data, little-endian
//   wb_en      out  1       one-cycle writeback strobe to register bank
//   wb_dest    out  4       writeback register index
//   wb_data    out  32      writeback data
//   busy       out  1       1 in REQ or WB
//   ld_err     out  1       one-cycle abort pulse (0 when macro absent)
// BEHAVIOUR
//   Reset: all outputs 0 except ld_ready=1; FSM=IDLE; latched fields cleared.
//   FSM IDLE -> REQ -> WB -> IDLE (REQ -> IDLE on timeout).
//   IDLE: ld_ready=1. On ld_valid&ld_ready at edge N: latch dest/size/signed,
//     ea = ld_base + sext(ld_offset) mod 2^32; next state REQ.
//   REQ (from N+1): mem_req=1, mem_addr={ea[31:2],2'b00}, stable until ack.
//     mem_ack sampled in REQ: capture lane, next WB. mem_ack outside REQ ignored.
//   Lane select: word=rdata; half=rdata[16*ea[1]+:16]; byte=rdata[8*ea[1:0]+:8];
//     ea[0] ignored for half, ea[1:0] ignored for word (no misalign error).
//   Extension: ld_signed ? sign : zero, to 32 bits.
//   WB: wb_en=1 exactly one cycle with wb_dest/wb_data; wb_dest/wb_data hold
//     last value afterward; next IDLE. Minimum latency accept->wb_en = 2 cycles
//     (ack in first REQ cycle); each extra ack wait cycle adds 1.
//   Back-to-back: new request accepted earliest the cycle after WB (ld_ready=0 in WB).
//   ld_valid while not ready is ignored; requester must hold it.
//   rst asserted mid-op: immediate return to IDLE, pending load dropped, no wb_en,
//     mem_req deasserts asynchronously.
//   busy = (state != IDLE).
// CONFIGURATION
//   LDR_TIMEOUT_EN defined: counter clears on entering REQ, increments each REQ cycle
//     without ack; when count reaches TIMEOUT-1 with no ack, next cycle: mem_req=0,
//     ld_err=1 for one cycle, no wb_en, state IDLE. Ack in the same cycle as the
//     terminal count wins (normal WB, no ld_err).
//   LDR_TIMEOUT_EN undefined: REQ waits for ack indefinitely; no counter; ld_err tied 0.
// TESTING
//   1 word: base=0x100, off=+4, rdata=0xDEADBEEF ack first REQ cycle -> mem_addr=0x104,
//     wb_en at accept+2, wb_dest=dest, wb_data=0xDEADBEEF.
//   2 signed byte: ea=0x203, rdata=0x80123456 -> wb_data=0xFFFFFF80; unsigned -> 0x00000080.
//   3 half: off=-2 from base 0x108 (ea=0x106), unsigned, rdata=0xABCD1234 -> mem_addr=0x104,
//     wb_data=0x0000ABCD.
//   4 ack delayed 5 cycles, then second load on ld_valid held high -> mem_req held 6
//     cycles, one wb_en per load, ld_ready=0 throughout REQ/WB.
//   5 rst pulse in REQ then late mem_ack -> no wb_en, ld_ready=1, mem_req=0.
//   6 LDR_TIMEOUT_EN, TIMEOUT=16, no ack -> ld_err single pulse after 16 REQ cycles, no wb_en;
//     repeat with ack on 16th REQ cycle -> normal wb_en, ld_err=0.

Source files
------------

// File: rtl/load_writeback_unit.sv
// Multi-cycle load unit feeding the register bank write port.
// Ports: ld_* request in, mem_* read port, wb_* writeback out, busy, ld_err.
// Optional macro LDR_TIMEOUT_EN: abort a read after TIMEOUT cycles without ack.
module load_writeback_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [3:0]        ld_dest,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [11:0]       ld_offset,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en,
  output logic [3:0]        wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              ld_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] ea;
  logic [ADDR_W-1:0] ea_nxt;
  logic [3:0]        dest_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [DATA_W-1:0] lane;
  logic [15:0]       half;
  logic [7:0]        byte_v;
  logic              accept;
  logic              timeout;

  assign accept   = ld_valid && (state == IDLE);
  assign ea_nxt   = ld_base + {{(ADDR_W-12){ld_offset[11]}}, ld_offset};
  assign mem_addr = {ea[ADDR_W-1:2], 2'b00};

  // Lane extraction; the low address bits below the access size are ignored.
  always_comb begin
    half   = ea[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    byte_v = 8'h00;
    unique case (ea[1:0])
      2'd0: byte_v = mem_rdata[7:0];
      2'd1: byte_v = mem_rdata[15:8];
      2'd2: byte_v = mem_rdata[23:16];
      2'd3: byte_v = mem_rdata[31:24];
    endcase
    lane = mem_rdata;
    unique case (size_q)
      2'b01:   lane = {{16{sgn_q & half[15]}}, half};
      2'b10:   lane = {{24{sgn_q & byte_v[7]}}, byte_v};
      default: lane = mem_rdata;
    endcase
  end

`ifdef LDR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;
  logic             err_q;

  // Ack on the terminal-count cycle takes priority over the abort.
  assign timeout = (state == REQ) && !mem_ack
                && (cnt == CNT_W'(TIMEOUT - 1));
  assign ld_err  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
      if (accept)
        cnt <= '0;
      else if (state == REQ && !mem_ack)
        cnt <= cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;

  assign timeout = 1'b0;
  assign ld_err  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    mem_req   = 1'b0;
    wb_en     = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        ld_ready = 1'b1;
        busy     = 1'b0;
        if (ld_valid)
          state_nxt = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack)
          state_nxt = WB;
        else if (timeout)
          state_nxt = IDLE;
      end
      WB: begin
        wb_en     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ea      <= '0;
      dest_q  <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      wb_dest <= '0;
      wb_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ea     <= ea_nxt;
        dest_q <= ld_dest;
        size_q <= ld_size;
        sgn_q  <= ld_signed;
      end
      if (state == REQ && mem_ack) begin
        wb_dest <= dest_q;
        wb_data <= lane;
      end
    end
  end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Directed self-checking bench for load_writeback_unit.
// Covers word/half/byte loads, back-to-back, reset abort, timeout.
module tb_load_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_dest;
  logic [31:0] ld_base;
  logic [11:0] ld_offset;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_data;
  logic        busy;
  logic        ld_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_writeback_unit #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_dest(ld_dest), .ld_base(ld_base),
    .ld_offset(ld_offset), .ld_size(ld_size),
    .ld_signed(ld_signed),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .busy(busy), .ld_err(ld_err)
  );

  // Issue one load and act as memory, acking on REQ cycle index 'delay'.
  task automatic run_load(
    input  logic [31:0] base,
    input  logic [11:0] off,
    input  logic [3:0]  dest,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  int          delay,
    input  logic [31:0] rdata,
    output logic [31:0] addr,
    output int          req_n,
    output int          wb_lat,
    output int          wb_n,
    output int          err_n,
    output int          rdy_bad,
    output logic [31:0] wdata,
    output logic [3:0]  wdest
  );
    int lim;
    lim = delay + 6;
    if (lim > 40) lim = 40;
    addr = '0; req_n = 0; wb_lat = -1; wb_n = 0;
    err_n = 0; rdy_bad = 0; wdata = '0; wdest = '0;
    ld_base = base; ld_offset = off; ld_dest = dest;
    ld_size = size; ld_signed = sgn; ld_valid = 1'b1;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    for (int k = 1; k <= lim; k++) begin
      if (mem_req) begin
        req_n++;
        addr = mem_addr;
      end
      if (wb_en) begin
        wb_n++;
        wb_lat = k;
        wdata = wb_data;
        wdest = wb_dest;
      end
      if (ld_err) err_n++;
      if ((mem_req || wb_en) && ld_ready) rdy_bad++;
      if (mem_req && (req_n - 1) == delay) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ld_ready, mem_req, wb_en, busy, ld_err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 10000",
               {ld_ready, mem_req, wb_en, busy, ld_err});
    end
    checks++;
    if ({mem_addr, wb_data, wb_dest} !== 68'd0) begin
      errors++;
      $display("FAIL reset_data: addr %h data %h dest %h want 0",
               mem_addr, wb_data, wb_dest);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ld_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready %b busy %b want 1 0",
               ld_ready, busy);
    end
  endtask

  task automatic test_word;
    logic [31:0] a, d;
    logic [3:0]  dst;
    int rq, lat, wn, en, rb;
    run_load(32'h100, 12'd4, 4'd5, 2'b00, 1'b0, 0,
             32'hDEAD_BEEF, a, rq, lat, wn, en, rb, d, dst);
    checks++;
    if (a !== 32'h104) begin
      errors++;
      $display("FAIL word_addr: got %h want 00000104", a);
    end
    checks++;
    if (lat !== 2 || wn !== 1 || rq !== 1) begin
      errors++;
      $display("FAIL word_timing: lat %0d wb %0d req %0d want 2 1 1",
               lat, wn, rq);
    end
    checks++;
    if (d !== 32'hDEAD_BEEF || dst !== 4'd5) begin
      errors++;
      $display("FAIL word_wb: data %h dest %0d want deadbeef 5", d, dst);
    end
    checks++;
    if (wb_data !== 32'hDEAD_BEEF || wb_en !== 1'b0 || rb !== 0) begin
      errors++;
      $display("FAIL word_hold: data %h en %b rdy_bad %0d",
               wb_data, wb_en, rb);
    end
  endtask

  task automatic test_byte;
    logic [31:0] a, d;
    logic [3:0]  dst;
    int rq, lat, wn, en, rb;
    run_load(32'h200, 12'd3, 4'd1, 2'b10, 1'b1, 0,
             32'h8012_3456, a, rq, lat, wn, en, rb, d, dst);
    checks++;
    if (d !== 32'hFFFF_FF80 || a !== 32'h200) begin
      errors++;
      $display("FAIL byte_signed: data %h addr %h want ffffff80 200", d, a);
    end
    run_load(32'h200, 12'd3, 4'd2, 2'b10, 1'b0, 0,
             32'h8012_3456, a, rq, lat, wn, en, rb, d, dst);
    checks++;
    if (d !== 32'h0000_0080 || dst !== 4'd2) begin
      errors++;
      $display("FAIL byte_unsigned: data %h dest %0d want 00000080 2",
               d, dst);
    end
    run_load(32'h200, 12'd1, 4'd3, 2'b10, 1'b1, 0,
             32'h8012_3456, a, rq, lat, wn, en, rb, d, dst);
    checks++;
    if (d !== 32'h0000_0034) begin
      errors++;
      $display("FAIL byte_lane1: data %h want 00000034", d);
    end
  endtask

  task automatic test_half;
    logic [31:0] a, d;
    logic [3:0]  dst;
    int rq, lat, wn, en, rb;
    run_load(32'h108, 12'hFFE, 4'd4, 2'b01, 1'b0, 0,
             32'hABCD_1234, a, rq, lat, wn, en, rb, d, dst);
    checks++;
    if (a !== 32'h104 || d !== 32'h0000_ABCD) begin
      errors++;
      $display("FAIL half_hi: addr %h data %h want 104 0000abcd", a, d);
    end
    run_load(32'h101, 12'd0, 4'd6, 2'b01, 1'b1, 0,
             32'h1234_F00D, a, rq, lat, wn, en, rb, d, dst);
    checks++;
    if (a !== 32'h100 || d !== 32'hFFFF_F00D) begin
      errors++;
      $display("FAIL half_lo_signed: addr %h data %h want 100 fffff00d",
               a, d);
    end
  endtask

  task automatic test_size3_wrap;
    logic [31:0] a, d;
    logic [3:0]  dst;
    int rq, lat, wn, en, rb;
    run_load(32'hFFFF_FFFC, 12'd9, 4'd9, 2'b11, 1'b1, 0,
             32'h8765_4321, a, rq, lat, wn, en, rb, d, dst);
    checks++;
    if (a !== 32'h4 || d !== 32'h8765_4321) begin
      errors++;
      $display("FAIL wrap_word: addr %h data %h want 4 87654321", a, d);
    end
  endtask

  task automatic test_back_to_back;
    int reqs, run, first_len, wbs, bad, wbk0, wbk1;
    logic [31:0] d0, d1;
    reqs = 0; run = 0; first_len = 0; wbs = 0; bad = 0;
    wbk0 = -1; wbk1 = -1; d0 = '0; d1 = '0;
    ld_base = 32'h300; ld_offset = 12'd0; ld_dest = 4'd7;
    ld_size = 2'b00; ld_signed = 1'b0; ld_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (mem_req) begin
        reqs++;
        run++;
      end else if (run > 0) begin
        if (first_len == 0) first_len = run;
        run = 0;
      end
      if (wb_en) begin
        if (wbs == 0) begin
          d0 = wb_data;
          wbk0 = k;
        end else begin
          d1 = wb_data;
          wbk1 = k;
        end
        wbs++;
        if (wbs == 2) ld_valid = 1'b0;
      end
      if ((mem_req || wb_en) && ld_ready) bad++;
      if (mem_req && run == ((wbs == 0) ? 6 : 1)) begin
        mem_ack = 1'b1;
        mem_rdata = (wbs == 0) ? 32'h1111_1111 : 32'h2222_2222;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
      end
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    mem_ack = 1'b0;
    checks++;
    if (first_len !== 6 || reqs !== 7) begin
      errors++;
      $display("FAIL b2b_req: first %0d total %0d want 6 7",
               first_len, reqs);
    end
    checks++;
    if (wbs !== 2 || d0 !== 32'h1111_1111 || d1 !== 32'h2222_2222) begin
      errors++;
      $display("FAIL b2b_wb: n %0d d0 %h d1 %h want 2 11111111 22222222",
               wbs, d0, d1);
    end
    checks++;
    if (bad !== 0 || (wbk1 - wbk0) !== 3) begin
      errors++;
      $display("FAIL b2b_ready: bad %0d gap %0d want 0 3",
               bad, wbk1 - wbk0);
    end
  endtask

  task automatic test_rst_mid;
    int wbn, reqn;
    wbn = 0; reqn = 0;
    ld_base = 32'h400; ld_offset = 12'd0; ld_dest = 4'd8;
    ld_size = 2'b00; ld_signed = 1'b0; ld_valid = 1'b1;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_req: mem_req %b want 1", mem_req);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || ld_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: req %b ready %b busy %b want 0 1 0",
               mem_req, ld_ready, busy);
    end
    #1 rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (wb_en) wbn++;
      if (mem_req || !ld_ready) reqn++;
    end
    checks++;
    if (wbn !== 0 || reqn !== 0 || wb_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_drop: wb %0d active %0d data %h want 0 0 0",
               wbn, reqn, wb_data);
    end
  endtask

`ifdef LDR_TIMEOUT_EN
  task automatic test_timeout;
    logic [31:0] a, d;
    logic [3:0]  dst;
    int rq, lat, wn, en, rb;
    run_load(32'h500, 12'd0, 4'd10, 2'b00, 1'b0, 1000,
             32'h0, a, rq, lat, wn, en, rb, d, dst);
    checks++;
    if (rq !== 16 || en !== 1 || wn !== 0) begin
      errors++;
      $display("FAIL timeout_abort: req %0d err %0d wb %0d want 16 1 0",
               rq, en, wn);
    end
    run_load(32'h500, 12'd0, 4'd11, 2'b00, 1'b0, 15,
             32'h1357_9BDF, a, rq, lat, wn, en, rb, d, dst);
    checks++;
    if (en !== 0 || wn !== 1 || d !== 32'h1357_9BDF || lat !== 17) begin
      errors++;
      $display("FAIL timeout_edge_ack: err %0d wb %0d data %h lat %0d",
               en, wn, d, lat);
    end
  endtask
`else
  task automatic test_long_wait;
    logic [31:0] a, d;
    logic [3:0]  dst;
    int rq, lat, wn, en, rb;
    run_load(32'h600, 12'd8, 4'd12, 2'b00, 1'b0, 20,
             32'h2468_ACE0, a, rq, lat, wn, en, rb, d, dst);
    checks++;
    if (rq !== 21 || lat !== 22 || en !== 0 || d !== 32'h2468_ACE0) begin
      errors++;
      $display("FAIL long_wait: req %0d lat %0d err %0d data %h",
               rq, lat, en, d);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    ld_valid = 1'b0; ld_dest = '0; ld_base = '0; ld_offset = '0;
    ld_size = '0; ld_signed = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_size3_wrap;
    test_back_to_back;
    test_rst_mid;
`ifdef LDR_TIMEOUT_EN
    test_timeout;
`else
    test_long_wait;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
